// File: rtl/median3_stream_pkg.sv
// Shared definitions for the median3_stream filter.
//
// Contents:
//   DefaultBits - default sample width for the filter and its sorter
//   state_e     - sequencing states of the window controller
//                 StEmpty : no sample of the current stream seen yet
//                 StRun   : window primed, each new sample emits one output
//                 StFlush : last sample taken, emit the trailing output
package median3_stream_pkg;

    localparam int unsigned DefaultBits = 4;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } state_e;

endpackage

// File: rtl/median3_stream_cas3.sv
// cas3: combinational three-input sorter built from three compare-and-swap stages.
//
// Ports:
//   a_i, b_i, c_i  - unsigned inputs in any order
//   a_new_o        - largest of the three
//   b_new_o        - median of the three
//   c_new_o        - smallest of the three
// Equal inputs are legal; outputs always satisfy a_new_o >= b_new_o >= c_new_o.
module cas3
    import median3_stream_pkg::*;
#(
    parameter int unsigned BITS = DefaultBits
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    input  logic [BITS-1:0] c_i,
    output logic [BITS-1:0] a_new_o,
    output logic [BITS-1:0] b_new_o,
    output logic [BITS-1:0] c_new_o
);

    logic [BITS-1:0] hi1, lo1;
    logic [BITS-1:0] mid2;

    always_comb begin
        // Stage 1: order a/b.
        if (a_i >= b_i) begin
            hi1 = a_i;
            lo1 = b_i;
        end else begin
            hi1 = b_i;
            lo1 = a_i;
        end

        // Stage 2: the larger of (hi1, c) is the overall maximum.
        if (hi1 >= c_i) begin
            a_new_o = hi1;
            mid2    = c_i;
        end else begin
            a_new_o = c_i;
            mid2    = hi1;
        end

        // Stage 3: the remaining two hold the median and minimum.
        if (mid2 >= lo1) begin
            b_new_o = mid2;
            c_new_o = lo1;
        end else begin
            b_new_o = lo1;
            c_new_o = mid2;
        end
    end

endmodule

// File: rtl/median3_stream.sv
// median3_stream: streaming 3-tap sliding-window max/median/min filter.
//
// Each accepted sample produces exactly one output triple. Stream ends are
// handled by replicating the edge sample: the first window is (x0, x0, x1),
// the last window is (x(n-2), x(n-1), x(n-1)).
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   in_valid   - upstream sample valid
//   in_ready   - filter can accept a sample this cycle
//   in_data    - unsigned input sample
//   in_last    - final sample of a stream (qualified by in_valid)
//   out_valid  - output triple valid
//   out_ready  - downstream accepts the output
//   out_max    - largest value in the window
//   out_med    - median of the window
//   out_min    - smallest value in the window
//   out_last   - output belongs to the final sample of a stream
module median3_stream
    import median3_stream_pkg::*;
#(
    parameter int unsigned BITS = DefaultBits
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_max,
    output logic [BITS-1:0] out_med,
    output logic [BITS-1:0] out_min,
    output logic            out_last
);

    state_e          state_q, state_d;
    logic [BITS-1:0] w_prev_q, w_prev_d;
    logic [BITS-1:0] w_cur_q, w_cur_d;
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_max_q, out_max_d;
    logic [BITS-1:0] out_med_q, out_med_d;
    logic [BITS-1:0] out_min_q, out_min_d;
    logic            out_last_q, out_last_d;

    logic            out_space;
    logic            in_xfer;
    logic            out_xfer;
    logic            load;
    logic            load_last;
    logic [BITS-1:0] cas_c;
    logic [BITS-1:0] cas_max, cas_med, cas_min;

    // The single output register may be refilled in the same cycle it drains,
    // which keeps the stream at one sample per cycle.
    assign out_space = !out_valid_q || out_ready;
    assign in_ready  = (state_q != StFlush) && out_space;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;

    // In FLUSH the newest sample is replicated to close the last window.
    assign cas_c = (state_q == StFlush) ? w_cur_q : in_data;

    cas3 #(
        .BITS (BITS)
    ) u_cas3 (
        .a_i     (w_prev_q),
        .b_i     (w_cur_q),
        .c_i     (cas_c),
        .a_new_o (cas_max),
        .b_new_o (cas_med),
        .c_new_o (cas_min)
    );

    always_comb begin
        state_d     = state_q;
        w_prev_d    = w_prev_q;
        w_cur_d     = w_cur_q;
        out_valid_d = out_valid_q;
        out_max_d   = out_max_q;
        out_med_d   = out_med_q;
        out_min_d   = out_min_q;
        out_last_d  = out_last_q;
        load        = 1'b0;
        load_last   = 1'b0;

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StEmpty: begin
                // First sample primes both taps so the first window is (x0, x0, x1).
                if (in_xfer) begin
                    w_prev_d = in_data;
                    w_cur_d  = in_data;
                    state_d  = in_last ? StFlush : StRun;
                end
            end
            StRun: begin
                if (in_xfer) begin
                    load     = 1'b1;
                    w_prev_d = w_cur_q;
                    w_cur_d  = in_data;
                    if (in_last) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (out_space) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    state_d   = StEmpty;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase

        // A new load takes priority over the drain above.
        if (load) begin
            out_valid_d = 1'b1;
            out_max_d   = cas_max;
            out_med_d   = cas_med;
            out_min_d   = cas_min;
            out_last_d  = load_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StEmpty;
            w_prev_q    <= '0;
            w_cur_q     <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_med_q   <= '0;
            out_min_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_prev_q    <= w_prev_d;
            w_cur_q     <= w_cur_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_med_q   <= out_med_d;
            out_min_q   <= out_min_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_med   = out_med_q;
    assign out_min   = out_min_q;
    assign out_last  = out_last_q;

endmodule
